passcode_lock: RTL and testbench

Parametrised passcode checker: accepts a stream of DIGITS strobed digits, compares the whole sequence against a stored code and opens on a match. It counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures. It sits between the keypad digit decoder and the unlock/indicator logic, and is the generalised, handshaked successor of the fixed 3-digit passcode FSM.

---
 rtl/passcode_pkg.sv | 13 +
 rtl/passcode_lock_if.sv | 43 ++++
 rtl/passcode_lockout_timer.sv | 29 ++
 rtl/passcode_lock.sv | 178 +++++++++++++++++
 tb/tb_passcode_lock.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/passcode_pkg.sv
// Shared state encoding for the passcode lock and its bus interface.
package passcode_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2,
        PROG    = 2'd3
    } state_e;

endpackage

// File: rtl/passcode_lock_if.sv
// Keypad-side bus of the passcode lock: digit strobe, controls and status.
// The prog signal exists only when PASSCODE_PROG_EN is defined.
interface passcode_lock_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    import passcode_pkg::*;

    localparam int IDX_W = $clog2(DIGITS);

    logic [DIGIT_W-1:0] din;
    logic               din_valid;
    logic               relock;
`ifdef PASSCODE_PROG_EN
    logic               prog;
`endif
    logic               correct;
    logic               fail;
    logic               locked;
    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   digit_idx;

`ifdef PASSCODE_PROG_EN
    modport master (
        output din, din_valid, relock, prog,
        input  correct, fail, locked, state, digit_idx
    );
    modport slave (
        input  din, din_valid, relock, prog,
        output correct, fail, locked, state, digit_idx
    );
`else
    modport master (
        output din, din_valid, relock,
        input  correct, fail, locked, state, digit_idx
    );
    modport slave (
        input  din, din_valid, relock,
        output correct, fail, locked, state, digit_idx
    );
`endif

endinterface

// File: rtl/passcode_lockout_timer.sv
// Load/decrement down-counter timing the lockout window; done while at zero.
module passcode_lockout_timer #(
    parameter int LOCKOUT_CYC = 16
) (
    input  logic clk,
    input  logic clr_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOCKOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_p1 <= '0;
        end else if (load) begin
            cnt_p1 <= LOAD_VAL;
        end else if (dec && (cnt_p1 != '0)) begin
            cnt_p1 <= cnt_p1 - 1'b1;
        end
    end

    assign done = (cnt_p1 == '0);

endmodule

// File: rtl/passcode_lock.sv
// Passcode checker: constant-time code comparison, failure count and timed lockout.
// Define PASSCODE_PROG_EN to add the prog control and a writable stored code.
module passcode_lock
    import passcode_pkg::*;
#(
    parameter int                          DIGITS      = 4,
    parameter int                          DIGIT_W     = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   INIT_CODE   = '0,
    parameter int                          MAX_TRIES   = 3,
    parameter int                          LOCKOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    passcode_lock_if.slave bus
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    function automatic logic [DIGIT_W-1:0] code_digit(
        input logic [CODE_W-1:0] code,
        input logic [IDX_W-1:0]  idx
    );
        code_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == k[IDX_W-1:0]) code_digit = code[k*DIGIT_W +: DIGIT_W];
        end
    endfunction

    state_e           state_p0, state_p1;
    logic [IDX_W-1:0] idx_p0,   idx_p1;
    logic             mis_p0,   mis_p1;
    logic [TRY_W-1:0] tries_p0, tries_p1;
    logic             correct_p0, correct_p1;
    logic             fail_p0,    fail_p1;
    logic             locked_p0,  locked_p1;

    logic [CODE_W-1:0]  code_w;
    logic [TRY_W-1:0]   tries_inc;
    logic               digit_bad;
    logic               tmr_load, tmr_dec, tmr_done;

`ifdef PASSCODE_PROG_EN
    logic [CODE_W-1:0]  code_p0, code_p1;
    assign code_w = code_p1;
`else
    assign code_w = INIT_CODE;
`endif

    assign digit_bad = (bus.din != code_digit(code_w, idx_p1));
    assign tries_inc = tries_p1 + 1'b1;

    passcode_lockout_timer #(
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_timer (
        .clk  (clk),
        .clr_n(clr_n),
        .load (tmr_load),
        .dec  (tmr_dec),
        .done (tmr_done)
    );

    // Stage 0: next-state decode, comparison and output precompute
    always_comb begin
        state_p0 = state_p1;
        idx_p0   = idx_p1;
        mis_p0   = mis_p1;
        tries_p0 = tries_p1;
        fail_p0  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
`ifdef PASSCODE_PROG_EN
        code_p0  = code_p1;
`endif
        case (state_p1)
            OPEN: begin
                if (bus.relock) begin
                    state_p0 = ENTRY;
`ifdef PASSCODE_PROG_EN
                end else if (bus.prog) begin
                    state_p0 = PROG;
                    idx_p0   = '0;
`endif
                end
            end
            LOCKOUT: begin
                if (tmr_done) state_p0 = ENTRY;
                else          tmr_dec  = 1'b1;
            end
`ifdef PASSCODE_PROG_EN
            PROG: begin
                if (bus.relock) begin
                    state_p0 = ENTRY;
                    idx_p0   = '0;
                end else if (bus.din_valid) begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (idx_p1 == k[IDX_W-1:0]) code_p0[k*DIGIT_W +: DIGIT_W] = bus.din;
                    end
                    if (idx_p1 == LAST_IDX) begin
                        idx_p0   = '0;
                        state_p0 = ENTRY;
                    end else begin
                        idx_p0 = idx_p1 + 1'b1;
                    end
                end
            end
`endif
            // ENTRY, and the unused encoding when programming is compiled out
            default: begin
                if (bus.din_valid) begin
                    if (idx_p1 == LAST_IDX) begin
                        idx_p0 = '0;
                        mis_p0 = 1'b0;
                        if (!(mis_p1 || digit_bad)) begin
                            state_p0 = OPEN;
                            tries_p0 = '0;
                        end else begin
                            fail_p0 = 1'b1;
                            if (tries_inc == TRY_LIMIT) begin
                                state_p0 = LOCKOUT;
                                tries_p0 = '0;
                                tmr_load = 1'b1;
                            end else begin
                                tries_p0 = tries_inc;
                            end
                        end
                    end else begin
                        idx_p0 = idx_p1 + 1'b1;
                        mis_p0 = mis_p1 | digit_bad;
                    end
                end else if (state_p1 != ENTRY) begin
                    state_p0 = ENTRY;
                end
            end
        endcase
        correct_p0 = (state_p0 == OPEN);
        locked_p0  = (state_p0 == LOCKOUT);
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_p1   <= ENTRY;
            idx_p1     <= '0;
            mis_p1     <= 1'b0;
            tries_p1   <= '0;
            correct_p1 <= 1'b0;
            fail_p1    <= 1'b0;
            locked_p1  <= 1'b0;
        end else begin
            state_p1   <= state_p0;
            idx_p1     <= idx_p0;
            mis_p1     <= mis_p0;
            tries_p1   <= tries_p0;
            correct_p1 <= correct_p0;
            fail_p1    <= fail_p0;
            locked_p1  <= locked_p0;
        end
    end

`ifdef PASSCODE_PROG_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) code_p1 <= INIT_CODE;
        else        code_p1 <= code_p0;
    end
`endif

    assign bus.correct   = correct_p1;
    assign bus.fail      = fail_p1;
    assign bus.locked    = locked_p1;
    assign bus.state     = state_p1;
    assign bus.digit_idx = idx_p1;

endmodule

// File: tb/tb_passcode_lock.sv
// Directed bench for passcode_lock with code C,C,D, 3 tries and a 16-cycle lockout.
module tb_passcode_lock;

    logic clk;
    logic clr_n;
    int   n_chk;
    int   n_fail;

    passcode_lock_if #(.DIGITS(3), .DIGIT_W(4)) bus ();

    passcode_lock #(
        .DIGITS     (3),
        .DIGIT_W    (4),
        .INIT_CODE  (12'hDCC),
        .MAX_TRIES  (3),
        .LOCKOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic digit(input logic [3:0] d);
        bus.din       = d;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        clr_n         = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.relock    = 1'b0;
`ifdef PASSCODE_PROG_EN
        bus.prog      = 1'b0;
`endif
        tick();
        tick();
        chk("rst_state",   32'(bus.state),     32'd0);
        chk("rst_idx",     32'(bus.digit_idx), 32'd0);
        chk("rst_correct", 32'(bus.correct),   32'd0);
        chk("rst_fail",    32'(bus.fail),      32'd0);
        chk("rst_locked",  32'(bus.locked),    32'd0);
        clr_n = 1'b1;

        // Correct code opens one cycle after the final digit
        digit(4'hC);
        chk("ok_idx1", 32'(bus.digit_idx), 32'd1);
        digit(4'hC);
        chk("ok_idx2", 32'(bus.digit_idx), 32'd2);
        chk("ok_corr_early", 32'(bus.correct), 32'd0);
        digit(4'hD);
        chk("ok_correct", 32'(bus.correct),   32'd1);
        chk("ok_state",   32'(bus.state),     32'd1);
        chk("ok_fail",    32'(bus.fail),      32'd0);
        chk("ok_idx0",    32'(bus.digit_idx), 32'd0);

        // relock beats a simultaneous digit in OPEN
        bus.relock = 1'b1;
        digit(4'hC);
        bus.relock = 1'b0;
        chk("relock_state",   32'(bus.state),     32'd0);
        chk("relock_idx",     32'(bus.digit_idx), 32'd0);
        chk("relock_correct", 32'(bus.correct),   32'd0);
        tick();
        chk("relock_drop", 32'(bus.digit_idx), 32'd0);

        // Wrong middle digit: no early abort, single fail pulse
        digit(4'hC);
        digit(4'h5);
        chk("bad_noabort", 32'(bus.digit_idx), 32'd2);
        chk("bad_nofail",  32'(bus.fail),      32'd0);
        digit(4'hD);
        chk("bad_fail",    32'(bus.fail),      32'd1);
        chk("bad_correct", 32'(bus.correct),   32'd0);
        chk("bad_idx",     32'(bus.digit_idx), 32'd0);
        chk("bad_state",   32'(bus.state),     32'd0);
        tick();
        chk("bad_pulse", 32'(bus.fail), 32'd0);

        // Asynchronous reset mid-entry
        digit(4'hC);
        digit(4'hC);
        chk("mid_idx", 32'(bus.digit_idx), 32'd2);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_idx",   32'(bus.digit_idx), 32'd0);
        chk("arst_state", 32'(bus.state),     32'd0);
        clr_n = 1'b1;
        tick();
        digit(4'hC);
        digit(4'hC);
        digit(4'hD);
        chk("arst_open", 32'(bus.correct), 32'd1);
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
        chk("arst_relock", 32'(bus.state), 32'd0);

        // Three consecutive failures, back-to-back strobes
        for (int a = 0; a < 3; a++) begin
            digit(4'h1);
            digit(4'h1);
            digit(4'h1);
            chk("lk_fail", 32'(bus.fail), 32'd1);
            chk("lk_locked", 32'(bus.locked), (a == 2) ? 32'd1 : 32'd0);
        end
        chk("lk_state", 32'(bus.state), 32'd2);
        for (int c = 1; c < 16; c++) begin
            bus.din       = 4'hC;
            bus.din_valid = 1'b1;
            tick();
            chk("lk_hold", 32'(bus.locked), 32'd1);
            chk("lk_ignore", 32'(bus.digit_idx), 32'd0);
        end
        bus.din_valid = 1'b0;
        tick();
        chk("lk_end_locked", 32'(bus.locked),    32'd0);
        chk("lk_end_state",  32'(bus.state),     32'd0);
        chk("lk_end_idx",    32'(bus.digit_idx), 32'd0);
        digit(4'hC);
        digit(4'hC);
        digit(4'hD);
        chk("lk_after_open", 32'(bus.correct), 32'd1);

`ifdef PASSCODE_PROG_EN
        // relock wins over prog, then program a new code 1,2,3
        bus.relock = 1'b1;
        bus.prog   = 1'b1;
        tick();
        bus.relock = 1'b0;
        bus.prog   = 1'b0;
        chk("pg_relock_wins", 32'(bus.state), 32'd0);
        digit(4'hC);
        digit(4'hC);
        digit(4'hD);
        chk("pg_reopen", 32'(bus.state), 32'd1);
        bus.prog = 1'b1;
        tick();
        bus.prog = 1'b0;
        chk("pg_state",   32'(bus.state),   32'd3);
        chk("pg_correct", 32'(bus.correct), 32'd0);
        digit(4'h1);
        digit(4'h2);
        digit(4'h3);
        chk("pg_done", 32'(bus.state), 32'd0);
        digit(4'hC);
        digit(4'hC);
        digit(4'hD);
        chk("pg_old_fails", 32'(bus.fail), 32'd1);
        digit(4'h1);
        digit(4'h2);
        digit(4'h3);
        chk("pg_new_opens", 32'(bus.correct), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
